// File: rtl/lockstep_sequencer_if.sv
// Peripheral request/response bus of the lockstep sequencer.
// The slave modport is the sequencer's view; the master modport is the requester's view.
interface lockstep_sequencer_if #(
    parameter int ID_WIDTH = 2
);
    logic                req_i;
    logic [31:0]         addr_i;
    logic                wen_i;
    logic [31:0]         wdata_i;
    logic [3:0]          be_i;
    logic [ID_WIDTH-1:0] id_i;

    logic                gnt_o;
    logic                r_valid_o;
    logic                r_opc_o;
    logic [ID_WIDTH-1:0] r_id_o;
    logic [31:0]         r_rdata_o;

    modport master (
        output req_i, addr_i, wen_i, wdata_i, be_i, id_i,
        input  gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o
    );

    modport slave (
        input  req_i, addr_i, wen_i, wdata_i, be_i, id_i,
        output gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o
    );
endinterface

// File: rtl/lockstep_sequencer.sv
// Lockstep sequencer: a small register-mapped FSM that waits for a set of cores
// to reach a barrier, holds the cluster in lockstep mode, drains on exit and
// raises a timeout interrupt if the barrier is not reached in time.
// Register map (addr[3:2]): 0 CTRL, 1 MASK, 2 TIMEOUT, 3 STATUS.
module lockstep_sequencer #(
    parameter int NB_CORES = 8,
    parameter int ID_WIDTH = 2,
    parameter int TMO_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    lockstep_sequencer_if.slave  bus,
    input  logic [NB_CORES-1:0]  barrier_matched_i,
    output logic                 lockstep_mode_o,
    output logic                 irq_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_TIMEOUT = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    state_t              state_q;
    logic [NB_CORES-1:0] mask_q;
    logic [TMO_W-1:0]    timeout_q;
    logic [NB_CORES-1:0] mask_lat_q;
    logic [TMO_W-1:0]    timeout_lat_q;
    logic [TMO_W-1:0]    cnt_q;
    logic                sticky_q;

    logic                addr_err;
    logic                wr_ok;
    logic [1:0]          reg_sel;
    logic                cmd_en;
    logic                enter_cmd;
    logic                exit_cmd;
    logic                clear_cmd;
    logic [31:0]         wmask;
    logic [NB_CORES-1:0] mask_d;
    logic [TMO_W-1:0]    timeout_d;
    logic [31:0]         rdata_d;
    logic                barrier_hit;
    logic                tmo_enabled;
    logic                tmo_expire;
    logic                unused_bits;

    // Every request is granted immediately; the response follows one cycle later.
    assign bus.gnt_o = bus.req_i;

    // Address decode, command extraction and byte-enable merging of the RW registers.
    always_comb begin
        addr_err  = |bus.addr_i[11:4];
        reg_sel   = bus.addr_i[3:2];
        wr_ok     = bus.req_i && !bus.wen_i && !addr_err;
        cmd_en    = wr_ok && bus.be_i[0];
        exit_cmd  = cmd_en && (reg_sel == REG_CTRL) && bus.wdata_i[1];
        enter_cmd = cmd_en && (reg_sel == REG_CTRL) && bus.wdata_i[0] && !bus.wdata_i[1];
        clear_cmd = cmd_en && (reg_sel == REG_STATUS) && bus.wdata_i[3];
        wmask     = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}}, {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};
        mask_d    = mask_q;
        timeout_d = timeout_q;
        if (wr_ok && (reg_sel == REG_MASK)) begin
            mask_d = (mask_q & ~wmask[NB_CORES-1:0]) | (bus.wdata_i[NB_CORES-1:0] & wmask[NB_CORES-1:0]);
        end
        if (wr_ok && (reg_sel == REG_TIMEOUT)) begin
            timeout_d = (timeout_q & ~wmask[TMO_W-1:0]) | (bus.wdata_i[TMO_W-1:0] & wmask[TMO_W-1:0]);
        end
    end

    // Read data reflects register contents before any write in the same cycle.
    always_comb begin
        rdata_d = '0;
        if (bus.req_i && bus.wen_i && !addr_err) begin
            case (reg_sel)
                REG_MASK:    rdata_d = 32'(mask_q);
                REG_TIMEOUT: rdata_d = 32'(timeout_q);
                REG_STATUS:  rdata_d = {27'd0, lockstep_mode_o, sticky_q, state_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    // Barrier and timeout conditions use the values latched when the sequence started.
    always_comb begin
        barrier_hit = (barrier_matched_i & mask_lat_q) == mask_lat_q;
        tmo_enabled = timeout_lat_q != '0;
        tmo_expire  = tmo_enabled && (cnt_q == TMO_W'(1));
    end

    assign unused_bits = ^{bus.addr_i[31:12], bus.addr_i[1:0], bus.wdata_i, wmask};

    // Software-visible configuration registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q    <= '1;
            timeout_q <= '0;
        end else begin
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    // Response path: one-cycle registered reply carrying the request id.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.r_valid_o <= 1'b0;
            bus.r_opc_o   <= 1'b0;
            bus.r_id_o    <= '0;
            bus.r_rdata_o <= '0;
        end else begin
            bus.r_valid_o <= bus.req_i;
            if (bus.req_i) begin
                bus.r_opc_o   <= addr_err;
                bus.r_id_o    <= ID_WIDTH'(bus.id_i);
                bus.r_rdata_o <= rdata_d;
            end
        end
    end

    // Sequencer FSM with registered lockstep, interrupt and sticky-error outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            mask_lat_q      <= '1;
            timeout_lat_q   <= '0;
            sticky_q        <= 1'b0;
            lockstep_mode_o <= 1'b0;
            irq_o           <= 1'b0;
        end else begin
            irq_o <= 1'b0;
            if (clear_cmd) begin
                sticky_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enter_cmd && (mask_q != '0)) begin
                        state_q       <= ST_SYNC;
                        cnt_q         <= timeout_q;
                        mask_lat_q    <= mask_q;
                        timeout_lat_q <= timeout_q;
                    end
                end
                ST_SYNC: begin
                    if (exit_cmd) begin
                        state_q <= ST_IDLE;
                    end else if (barrier_hit) begin
                        state_q         <= ST_ACTIVE;
                        lockstep_mode_o <= 1'b1;
                    end else if (tmo_expire) begin
                        state_q  <= ST_ERROR;
                        irq_o    <= 1'b1;
                        sticky_q <= 1'b1;
                    end else if (tmo_enabled) begin
                        cnt_q <= cnt_q - TMO_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (exit_cmd) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= timeout_lat_q;
                    end
                end
                ST_DRAIN: begin
                    if (barrier_hit) begin
                        state_q         <= ST_IDLE;
                        lockstep_mode_o <= 1'b0;
                    end else if (tmo_expire) begin
                        state_q         <= ST_ERROR;
                        lockstep_mode_o <= 1'b0;
                        irq_o           <= 1'b1;
                        sticky_q        <= 1'b1;
                    end else if (tmo_enabled) begin
                        cnt_q <= cnt_q - TMO_W'(1);
                    end
                end
                ST_ERROR: begin
                    if (clear_cmd) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    lockstep_mode_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lockstep_sequencer.sv
// Self-checking bench for lockstep_sequencer: bus accesses push their expected
// response into a queue, a monitor pops and compares each response as it appears.
module tb_lockstep_sequencer;

    localparam logic [31:0] A_CTRL    = 32'h0;
    localparam logic [31:0] A_MASK    = 32'h4;
    localparam logic [31:0] A_TIMEOUT = 32'h8;
    localparam logic [31:0] A_STATUS  = 32'hC;

    typedef struct {
        logic [1:0]  id;
        logic        opc;
        logic [31:0] rdata;
    } resp_t;

    logic       clk;
    logic       rst;
    logic [7:0] barrier;
    logic       lockstep;
    logic       irq;
    logic [1:0] next_id;
    int         checks;
    int         errors;
    resp_t      exp_q[$];

    lockstep_sequencer_if #(.ID_WIDTH(2)) periph_bus ();

    lockstep_sequencer #(
        .NB_CORES (8),
        .ID_WIDTH (2),
        .TMO_W    (16)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .bus               (periph_bus),
        .barrier_matched_i (barrier),
        .lockstep_mode_o   (lockstep),
        .irq_o             (irq)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One bus access lasting one cycle; the expected response is queued.
    task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_opc);
        resp_t e;
        @(negedge clk);
        periph_bus.req_i   = 1'b1;
        periph_bus.wen_i   = wen;
        periph_bus.addr_i  = addr;
        periph_bus.wdata_i = wdata;
        periph_bus.be_i    = be;
        periph_bus.id_i    = next_id;
        e.id    = next_id;
        e.opc   = exp_opc;
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        next_id = next_id + 2'd1;
        #1 checkOutput("gnt", {31'd0, periph_bus.gnt_o}, 32'd1);
        @(posedge clk);
        #1 periph_bus.req_i = 1'b0;
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        applyStimulus(1'b0, addr, data, be, 32'd0, 1'b0);
    endtask

    task automatic read_reg(input logic [31:0] addr, input logic [31:0] exp_rdata);
        applyStimulus(1'b1, addr, 32'd0, 4'hF, exp_rdata, 1'b0);
    endtask

    // Response monitor: every r_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin : resp_monitor
        resp_t e;
        if (periph_bus.r_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("rvalid_spurious", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("r_id", {30'd0, periph_bus.r_id_o}, {30'd0, e.id});
                checkOutput("r_opc", {31'd0, periph_bus.r_opc_o}, {31'd0, e.opc});
                checkOutput("r_rdata", periph_bus.r_rdata_o, e.rdata);
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        next_id = 2'd0;
        rst     = 1'b1;
        barrier = 8'h00;
        periph_bus.req_i   = 1'b0;
        periph_bus.wen_i   = 1'b1;
        periph_bus.addr_i  = 32'd0;
        periph_bus.wdata_i = 32'd0;
        periph_bus.be_i    = 4'h0;
        periph_bus.id_i    = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_rvalid", {31'd0, periph_bus.r_valid_o}, 32'd0);
        checkOutput("rst_ropc", {31'd0, periph_bus.r_opc_o}, 32'd0);
        checkOutput("rst_rid", {30'd0, periph_bus.r_id_o}, 32'd0);
        checkOutput("rst_rdata", periph_bus.r_rdata_o, 32'd0);
        checkOutput("rst_lockstep", {31'd0, lockstep}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        checkOutput("gnt_idle", {31'd0, periph_bus.gnt_o}, 32'd0);
        read_reg(A_STATUS, 32'h0);
        read_reg(A_MASK, 32'hFF);
        read_reg(A_TIMEOUT, 32'h0);
        read_reg(A_CTRL, 32'h0);

        $display("[TB] ignored commands and decode errors");
        write_reg(A_CTRL, 32'h3, 4'hF);
        read_reg(A_STATUS, 32'h0);
        write_reg(A_CTRL, 32'h1, 4'hE);
        read_reg(A_STATUS, 32'h0);
        applyStimulus(1'b1, 32'h10, 32'd0, 4'hF, 32'd0, 1'b1);
        applyStimulus(1'b0, 32'h14, 32'h0, 4'hF, 32'd0, 1'b1);
        read_reg(A_MASK, 32'hFF);
        write_reg(A_MASK, 32'h0, 4'h1);
        write_reg(A_CTRL, 32'h1, 4'h1);
        read_reg(A_STATUS, 32'h0);

        $display("[TB] enter then exit from sync");
        write_reg(A_MASK, 32'h01, 4'h1);
        write_reg(A_CTRL, 32'h1, 4'h1);
        read_reg(A_STATUS, 32'h1);
        write_reg(A_CTRL, 32'h2, 4'h1);
        read_reg(A_STATUS, 32'h0);

        $display("[TB] barrier sync into active");
        write_reg(A_MASK, 32'h0F, 4'h1);
        write_reg(A_CTRL, 32'h1, 4'h1);
        read_reg(A_STATUS, 32'h1);
        @(negedge clk);
        barrier = 8'hF7;
        checkOutput("sync_lockstep_low", {31'd0, lockstep}, 32'd0);
        read_reg(A_STATUS, 32'h1);
        @(negedge clk);
        barrier = 8'h0F;
        checkOutput("sync_lockstep_low2", {31'd0, lockstep}, 32'd0);
        @(negedge clk);
        checkOutput("active_lockstep", {31'd0, lockstep}, 32'd1);
        read_reg(A_STATUS, 32'h12);
        barrier = 8'h00;

        $display("[TB] exit and drain with latched mask");
        write_reg(A_MASK, 32'hFF, 4'h1);
        read_reg(A_MASK, 32'hFF);
        write_reg(A_CTRL, 32'h2, 4'h1);
        read_reg(A_STATUS, 32'h13);
        @(negedge clk);
        checkOutput("drain_lockstep", {31'd0, lockstep}, 32'd1);
        barrier = 8'h0F;
        @(negedge clk);
        checkOutput("drain_done_lockstep", {31'd0, lockstep}, 32'd0);
        read_reg(A_STATUS, 32'h0);
        barrier = 8'h00;

        $display("[TB] byte enables and timeout");
        write_reg(A_TIMEOUT, 32'h1234, 4'h2);
        read_reg(A_TIMEOUT, 32'h1200);
        write_reg(A_TIMEOUT, 32'h5, 4'h3);
        read_reg(A_TIMEOUT, 32'h5);
        write_reg(A_MASK, 32'h0, 4'h2);
        read_reg(A_MASK, 32'hFF);
        write_reg(A_CTRL, 32'h1, 4'h1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("irq_before_%0d", k), {31'd0, irq}, 32'd0);
        end
        @(negedge clk);
        checkOutput("irq_pulse", {31'd0, irq}, 32'd1);
        checkOutput("error_lockstep", {31'd0, lockstep}, 32'd0);
        @(negedge clk);
        checkOutput("irq_after", {31'd0, irq}, 32'd0);
        read_reg(A_STATUS, 32'h0C);
        write_reg(A_STATUS, 32'h8, 4'h0);
        write_reg(A_CTRL, 32'h2, 4'h1);
        read_reg(A_STATUS, 32'h0C);
        write_reg(A_STATUS, 32'h8, 4'h1);
        read_reg(A_STATUS, 32'h0);

        $display("[TB] match beats timeout in same cycle");
        write_reg(A_CTRL, 32'h1, 4'h1);
        repeat (5) @(negedge clk);
        barrier = 8'hFF;
        @(negedge clk);
        checkOutput("race_lockstep", {31'd0, lockstep}, 32'd1);
        checkOutput("race_irq", {31'd0, irq}, 32'd0);
        read_reg(A_STATUS, 32'h12);
        barrier = 8'h00;

        $display("[TB] reset while active");
        write_reg(A_MASK, 32'h0F, 4'h1);
        @(negedge clk);
        rst = 1'b1;
        periph_bus.req_i  = 1'b1;
        periph_bus.wen_i  = 1'b1;
        periph_bus.addr_i = A_STATUS;
        periph_bus.be_i   = 4'hF;
        @(posedge clk);
        #1 periph_bus.req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_active_lockstep", {31'd0, lockstep}, 32'd0);
        checkOutput("rst_drop_rvalid", {31'd0, periph_bus.r_valid_o}, 32'd0);
        read_reg(A_STATUS, 32'h0);
        read_reg(A_MASK, 32'hFF);
        read_reg(A_TIMEOUT, 32'h0);

        repeat (2) @(negedge clk);
        checkOutput("pending_resp", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
